// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: programmable NUM_F x 2**IN_W truth-table generator.
// Ports: clk, rst_n, cfg_we/cfg_fsel/cfg_data (LUT load), start, busy,
//   row_valid/row_ready/row_idx/row_out (row stream), done;
//   group_mark only when TTS_GROUP_MARK_EN is defined.
module truth_table_sweeper #(
  parameter int IN_W       = 4,
  parameter int NUM_F      = 10,
  parameter int SETTLE_CYC = 2,
  localparam int ROWS      = 1 << IN_W,
  localparam int FSW       = (NUM_F > 1) ? $clog2(NUM_F) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [FSW-1:0]  cfg_fsel,
  input  logic [ROWS-1:0] cfg_data,
  input  logic            start,
  output logic            busy,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [IN_W-1:0] row_idx,
  output logic [NUM_F-1:0] row_out,
`ifdef TTS_GROUP_MARK_EN
  output logic            group_mark,
`endif
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]      cnt;
  logic [ROWS-1:0] lut [NUM_F];
  logic [NUM_F-1:0] col;
  logic            last_row;
  logic            settle_end;
  logic            hs;
  logic            lut_we;

  assign last_row   = row_idx == IN_W'(ROWS - 1);
  assign settle_end = cnt == 8'(SETTLE_CYC - 1);
  assign hs         = row_valid & row_ready;
  assign lut_we     = cfg_we && (state == S_IDLE)
                   && (32'(cfg_fsel) < NUM_F);

  always_comb begin
    col = '0;
    for (int f = 0; f < NUM_F; f++) begin
      col[f] = lut[f][row_idx];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_end) state_nxt = S_PRESENT;
      S_PRESENT: if (hs) state_nxt = last_row ? S_DONE : S_SETTLE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      row_idx   <= '0;
      row_out   <= '0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            row_idx <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 8'd1;
          if (settle_end) begin
            row_out   <= col;
            row_valid <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (hs) begin
            row_valid <= 1'b0;
            if (last_row) begin
              done <= 1'b1;
            end else begin
              row_idx <= row_idx + IN_W'(1);
              cnt     <= '0;
            end
          end
        end
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_F; f++) begin
        lut[f] <= '0;
      end
    end else if (lut_we) begin
      lut[cfg_fsel] <= cfg_data;
    end
  end

`ifdef TTS_GROUP_MARK_EN
  generate
    if (IN_W >= 2) begin : g_gm
      assign group_mark = row_valid & (&row_idx[1:0]);
    end else begin : g_gm1
      assign group_mark = row_valid;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed self-checking bench.
// Covers reset, sweep, backpressure, ignored controls, mid-sweep reset.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_fsel;
  logic [15:0] cfg_data;
  logic        start;
  logic        busy;
  logic        row_valid;
  logic        row_ready;
  logic [3:0]  row_idx;
  logic [9:0]  row_out;
  logic        done;
`ifdef TTS_GROUP_MARK_EN
  logic        group_mark;
`endif

  int checks = 0;
  int errors = 0;

  truth_table_sweeper #(
    .IN_W(4),
    .NUM_F(10),
    .SETTLE_CYC(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_fsel(cfg_fsel),
    .cfg_data(cfg_data),
    .start(start),
    .busy(busy),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_idx(row_idx),
    .row_out(row_out),
`ifdef TTS_GROUP_MARK_EN
    .group_mark(group_mark),
`endif
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(row_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_idx"}, 32'(row_idx), 0);
    chk({tag, "_out"}, 32'(row_out), 0);
  endtask

  task automatic run_sweep(input int stall_idx,
                           input int stall_len,
                           input bit disturb,
                           input int abort_idx,
                           input logic [15:0] f0,
                           input logic [15:0] f5,
                           input int done_edge);
    int n;
    int st;
    int exp_idx;
    int rows;
    int dones;
    int first;
    bit held;
    logic [3:0] s_idx;
    logic [9:0] s_out;
    logic exp_gm;
    n = 0; st = 0; exp_idx = 0; rows = 0;
    dones = 0; first = -1; held = 0;
    s_idx = '0; s_out = '0; exp_gm = 1'b0;
    start = 1'b1;
    row_ready = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    chk("busy_start", 32'(busy), 1);
    while (n < 200) begin
      tick();
      n++;
      cfg_we = 1'b0;
      start = 1'b0;
      exp_gm = row_valid && ((exp_idx & 3) == 3);
`ifdef TTS_GROUP_MARK_EN
      chk("group_mark", 32'(group_mark), 32'(exp_gm));
`endif
      if (done) begin
        dones++;
        chk("done_edge", n, done_edge);
      end
      if (!busy) break;
      if (row_valid) begin
        if (first < 0) begin
          first = n;
          chk("first_valid", n, 2);
        end
        if (!held) begin
          chk("idx", 32'(row_idx), exp_idx);
          chk("f0", 32'(row_out[0]), 32'(f0[exp_idx]));
          chk("f5", 32'(row_out[5]), 32'(f5[exp_idx]));
          chk("f_other", 32'(row_out & 10'h3de), 0);
          rows++;
          s_idx = row_idx;
          s_out = row_out;
        end else begin
          chk("hold_idx", 32'(row_idx), 32'(s_idx));
          chk("hold_out", 32'(row_out), 32'(s_out));
        end
        if (exp_idx == abort_idx) begin
          #2 rst_n = 1'b0;
          #1 chk_zero("abort");
          return;
        end
        if (disturb && exp_idx == 6 && !held) begin
          cfg_we = 1'b1;
          cfg_fsel = 4'd0;
          cfg_data = 16'hffff;
          start = 1'b1;
        end
        if (exp_idx == stall_idx && st < stall_len) begin
          row_ready = 1'b0;
          st++;
          held = 1'b1;
        end else begin
          row_ready = 1'b1;
          held = 1'b0;
          exp_idx++;
        end
      end else begin
        row_ready = 1'b1;
      end
    end
    chk("timeout", 32'(busy), 0);
    chk("rows", rows, 16);
    chk("dones", dones, 1);
    chk("busy_end", n, done_edge + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_fsel = '0;
    cfg_data = '0;
    start = 1'b0;
    row_ready = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(row_valid), 0);

    cfg_we = 1'b1;
    cfg_fsel = 4'd0;
    cfg_data = 16'h8888;
    tick();
    cfg_fsel = 4'd5;
    cfg_data = 16'h111f;
    tick();
    cfg_fsel = 4'd12;
    cfg_data = 16'hffff;
    tick();
    cfg_we = 1'b0;
    tick();

    run_sweep(-1, 0, 1'b0, -1, 16'h8888, 16'h111f, 48);
    tick();
    run_sweep(2, 5, 1'b0, -1, 16'h8888, 16'h111f, 53);
    tick();
    run_sweep(-1, 0, 1'b1, -1, 16'h8888, 16'h111f, 48);
    tick();
    run_sweep(-1, 0, 1'b0, 9, 16'h8888, 16'h111f, 48);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_busy", 32'(busy), 0);
    chk("post_valid", 32'(row_valid), 0);

    cfg_we = 1'b1;
    cfg_fsel = 4'd0;
    cfg_data = 16'h8888;
    run_sweep(-1, 0, 1'b0, -1, 16'h8888, 16'h0000, 48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
